// File: rtl/eclk_bus_sync_pkg.sv
// eclk_bus_sync shared types and E-phase constants.
// Imported by the bus interface, the one-hot checker and the top.
package eclk_bus_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CYCLE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int E_HIGH_FIRST = 6;
  localparam int E_LAST       = 9;
  localparam int E_PERIOD     = 10;

  // e is registered, so it must be primed one phase before it goes high
  function automatic logic e_next(
    input logic [E_PERIOD-1:0] ph
  );
    return |ph[E_LAST-1:E_HIGH_FIRST-1];
  endfunction

endpackage

// File: rtl/eclk_bus_sync_if.sv
// CPU / peripheral bundle for the E-clock bus cycle controller.
// master drives requests and phase enables, slave is the controller.
interface eclk_bus_sync_if #(
  parameter int DW = 8
) ();
  import eclk_bus_sync_pkg::*;

  logic [E_PERIOD-1:0] eclk;
  logic                req;
  logic                rw;
  logic [DW-1:0]       wdata;
  logic [DW-1:0]       rdata_bus;
  logic                vma;
  logic                e;
  logic                per_rw;
  logic [DW-1:0]       per_wdata;
  logic                per_sel;
  logic [DW-1:0]       rdata;
  logic                ack;
  logic                sync_err;

  modport master (
    output eclk, req, rw, wdata, rdata_bus,
    input  vma, e, per_rw, per_wdata,
    input  per_sel, rdata, ack, sync_err
  );

  modport slave (
    input  eclk, req, rw, wdata, rdata_bus,
    output vma, e, per_rw, per_wdata,
    output per_sel, rdata, ack, sync_err
  );

endinterface

// File: rtl/eclk_onehot_check.sv
// Combinational one-hot detector for the E-phase enables.
// onehot_o is low for zero bits or for more than one bit set.
module eclk_onehot_check
  import eclk_bus_sync_pkg::*;
(
  input  logic [E_PERIOD-1:0] eclk_i,
  output logic                onehot_o
);

  logic [E_PERIOD-1:0] low_cleared;

  assign low_cleared = eclk_i & (eclk_i - E_PERIOD'(1));
  assign onehot_o    = (eclk_i != '0) && (low_cleared == '0);

endmodule

// File: rtl/eclk_bus_sync.sv
// 6800-style VMA/E bus cycle controller for the CIA register space.
// One E-aligned peripheral cycle per CPU request, then a one-cycle ack.
module eclk_bus_sync
  import eclk_bus_sync_pkg::*;
#(
  parameter int DW        = 8,
  parameter int VMA_PHASE = 3
) (
  input logic           clk,
  input logic           reset,
  eclk_bus_sync_if.slave bus
);

  state_t        state_q;
  logic          vma_q;
  logic          e_q;
  logic          e_d;
  logic          per_rw_q;
  logic [DW-1:0] per_wdata_q;
  logic [DW-1:0] rdata_q;
  logic          ack_q;
  logic          sync_err_q;
  logic          sync_err_d;
  logic          drop_q;
  logic          onehot;

  eclk_onehot_check u_chk (
    .eclk_i   (bus.eclk),
    .onehot_o (onehot)
  );

  assign e_d        = e_next(bus.eclk);
  assign sync_err_d = sync_err_q | ~onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vma_q       <= 1'b0;
      e_q         <= 1'b0;
      per_rw_q    <= 1'b1;
      per_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      sync_err_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      e_q        <= e_d;
      sync_err_q <= sync_err_d;
      ack_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req) state_q <= ARMED;
        end
        ARMED: begin
          if (!bus.req) begin
            state_q <= IDLE;
          end else if (bus.eclk[VMA_PHASE]) begin
            per_rw_q    <= bus.rw;
            per_wdata_q <= bus.wdata;
            vma_q       <= 1'b1;
            drop_q      <= 1'b0;
            state_q     <= CYCLE;
          end
        end
        CYCLE: begin
          // a started 6800 cycle always runs out; a lost req only kills ack
          if (bus.eclk[E_LAST]) begin
            if (per_rw_q) rdata_q <= bus.rdata_bus;
            vma_q    <= 1'b0;
            per_rw_q <= 1'b1;
            if (drop_q || !bus.req) begin
              state_q <= IDLE;
            end else begin
              ack_q   <= 1'b1;
              state_q <= DONE;
            end
          end else if (!bus.req) begin
            drop_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= bus.req ? ARMED : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vma       = vma_q;
  assign bus.e         = e_q;
  assign bus.per_rw    = per_rw_q;
  assign bus.per_wdata = per_wdata_q;
  assign bus.per_sel   = vma_q & e_q;
  assign bus.rdata     = rdata_q;
  assign bus.ack       = ack_q;
  assign bus.sync_err  = sync_err_q;

endmodule
